fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter and fetch controller for the instruction ROM. Drives the ROM address each cycle and sequences a program from a Start pulse to a Halt. Supports sequential fetch, stalls, and absolute or PC-relative branches. Reports completion with a sticky Done flag and counts retired instructions. It sits between the top-level test harness / decode stage and the instruction ROM; the ROM read is combinational on the address this block drives.

## Interface
Parameters:
- IW, 16, instruction address width (ROM depth 2**IW)
- DW, 9, instruction width
- START_ADDR, 0, PC load value on reset and on every accepted Start

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  begin program; accepted only in IDLE or DONE
- Stall  input  1  hold PC this cycle (downstream not ready)
- Halt  input  1  current instruction is the halt/done opcode (from decode)
- BranchEn  input  1  take branch this cycle
- BranchRel  input  1  1 = PC-relative (Target is signed two's complement), 0 = absolute
- Target  input  IW  branch target or signed offset
- InstIn  input  DW  instruction word returned by the ROM for InstAddress
- InstAddress  output  IW  ROM address (registered PC)
- InstOut  output  DW  InstIn gated: equals InstIn when InstValid, else all zeros
- InstValid  output  1  high exactly when state is RUN
- Done  output  1  sticky completion flag
- InstCount  output  16  retired-instruction counter, saturating
- WrapErr  output  1  sequential fetch overran top of ROM (see Configuration)

## Operation
- States: IDLE, RUN, DONE; encoding free.
- IDLE: PC = START_ADDR. Start=1 -> RUN, PC = START_ADDR, InstCount = 0, WrapErr = 0.
- RUN, per cycle, priority Halt > Stall > BranchEn > increment:
  - Halt=1: -> DONE, PC holds, InstCount += 1. Halt is honoured even while Stall=1.
  - Stall=1 (Halt=0): PC holds, InstCount holds, BranchEn ignored.
  - BranchEn=1: absolute: PC = Target; relative: PC = (PC + Target) mod 2**IW. InstCount += 1.
  - Otherwise: PC = PC + 1. InstCount += 1.
- Start is ignored in RUN.
- DONE: PC holds, Done = 1. Start=1 -> RUN, PC = START_ADDR, Done = 0, InstCount = 0, WrapErr = 0.
- InstCount saturates at 16'hFFFF and never wraps.
- Branch, Stall, and Halt inputs are ignored outside RUN.

## Timing
- Reset, from the edge where Reset=1 is sampled: state IDLE, InstAddress = START_ADDR, InstValid = 0, InstOut = 0, Done = 0, InstCount = 0, WrapErr = 0.
- Reset overrides all inputs, including mid-RUN and in the same cycle as Start.
- Start sampled at edge N -> InstValid = 1 and InstAddress = START_ADDR after edge N.
- Fetch latency: zero cycles from address to instruction. InstOut is combinational from InstIn; PC update takes effect after one edge.
- Branch or Halt decided at edge N applies to InstAddress after edge N. There is no delay slot.
- Done rises the cycle after Halt is sampled. InstValid falls in the same cycle.

## Configuration
- FETCH_WRAP_GUARD_EN defined:
  - A sequential increment from PC = 2**IW-1 does not wrap. The block enters DONE with WrapErr = 1 and Done = 1, and PC holds at 2**IW-1.
  - The instruction at that address is still counted.
  - Branches are never guarded; relative branches wrap modulo 2**IW.
- FETCH_WRAP_GUARD_EN undefined:
  - PC wraps 2**IW-1 -> 0 and execution continues.
  - WrapErr is tied to 0.

## Test plan
- Reset, then Start pulse, with no branch, stall, or halt for 5 cycles -> InstAddress 0,1,2,3,4; InstCount = 5; InstValid = 1; Done = 0.
- At PC = 3: BranchEn=1, BranchRel=0, Target=16'h0040 -> next InstAddress 0x0040. At PC = 0x0040: BranchRel=1, Target=16'hFFFE (-2) -> next InstAddress 0x003E.
- Stall=1 for 3 cycles at PC = 7, with BranchEn=1 also asserted -> InstAddress stays 7 and InstCount is unchanged. After release, increments to 8.
- Halt=1 at PC = 0x0010 with InstCount = 9 -> next cycle Done = 1, InstValid = 0, InstOut = 0, InstCount = 10. A later Start -> InstAddress 0, Done = 0, InstCount = 0.
- Absolute branch to 0xFFFF, then run one cycle -> with FETCH_WRAP_GUARD_EN: Done = 1, WrapErr = 1, InstAddress = 0xFFFF. Without it: InstAddress = 0x0000, state stays RUN.
- Reset asserted mid-RUN at PC = 0x0025 in the same cycle as Halt -> IDLE, InstAddress = START_ADDR, Done = 0, InstCount = 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// PC and fetch controller for the instruction ROM: IDLE/RUN/DONE sequencing.
// Optional FETCH_WRAP_GUARD_EN stops sequential fetch at the top of ROM.
module fetch_sequencer #(
  parameter int IW         = 16,
  parameter int DW         = 9,
  parameter int START_ADDR = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [IW-1:0] Target,
  input  logic [DW-1:0] InstIn,
  output logic [IW-1:0] InstAddress,
  output logic [DW-1:0] InstOut,
  output logic          InstValid,
  output logic          Done,
  output logic [15:0]   InstCount,
  output logic          WrapErr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] START_PC = IW'(START_ADDR);

  logic [1:0]    state;
  logic [IW-1:0] pc;
  logic [15:0]   cnt;
  logic [15:0]   cnt_inc;
  logic [IW-1:0] br_pc;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign br_pc   = BranchRel ? pc + Target : Target;

`ifdef FETCH_WRAP_GUARD_EN
  logic wrap;
  logic at_top;

  assign at_top = (pc == {IW{1'b1}});
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= START_PC;
      cnt   <= '0;
`ifdef FETCH_WRAP_GUARD_EN
      wrap  <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_RUN: begin
          if (Halt) begin
            state <= S_DONE;
            cnt   <= cnt_inc;
          end else if (!Stall) begin
            cnt <= cnt_inc;
            if (BranchEn) begin
              pc <= br_pc;
`ifdef FETCH_WRAP_GUARD_EN
            end else if (at_top) begin
              // last word still retires; PC parks on it
              state <= S_DONE;
              wrap  <= 1'b1;
`endif
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        S_IDLE, S_DONE: begin
          if (state == S_IDLE) begin
            pc <= START_PC;
          end
          if (Start) begin
            state <= S_RUN;
            pc    <= START_PC;
            cnt   <= '0;
`ifdef FETCH_WRAP_GUARD_EN
            wrap  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
          pc    <= START_PC;
        end
      endcase
    end
  end

  assign InstAddress = pc;
  assign InstValid   = (state == S_RUN);
  assign InstOut     = InstValid ? InstIn : '0;
  assign Done        = (state == S_DONE);
  assign InstCount   = cnt;

`ifdef FETCH_WRAP_GUARD_EN
  assign WrapErr = wrap;
`else
  assign WrapErr = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer with a combinational ROM model.
// Honours FETCH_WRAP_GUARD_EN for the top-of-ROM case.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Stall;
  logic        Halt;
  logic        BranchEn;
  logic        BranchRel;
  logic [15:0] Target;
  logic [8:0]  InstIn;
  logic [15:0] InstAddress;
  logic [8:0]  InstOut;
  logic        InstValid;
  logic        Done;
  logic [15:0] InstCount;
  logic        WrapErr;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(
    .IW(16), .DW(9), .START_ADDR(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .BranchRel(BranchRel),
    .Target(Target), .InstIn(InstIn),
    .InstAddress(InstAddress), .InstOut(InstOut),
    .InstValid(InstValid), .Done(Done),
    .InstCount(InstCount), .WrapErr(WrapErr)
  );

  always #5 Clk = ~Clk;

  function automatic logic [8:0] rom(input logic [15:0] a);
    return a[8:0] ^ 9'h1A5;
  endfunction

  assign InstIn = rom(InstAddress);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    Start = 0; Stall = 0; Halt = 0;
    BranchEn = 0; BranchRel = 0; Target = '0;
  endtask

  task automatic reset_start();
    Reset = 1; step(); Reset = 0;
    Start = 1; step(); Start = 0;
  endtask

  initial begin
    Reset = 1;
    idle_in();
    step(); step();
    Reset = 0;

    check("rst_addr",  InstAddress, 0);
    check("rst_valid", InstValid,   0);
    check("rst_out",   InstOut,     0);
    check("rst_done",  Done,        0);
    check("rst_cnt",   InstCount,   0);
    check("rst_wrap",  WrapErr,     0);

    Start = 1; step(); Start = 0;
    check("st_addr",  InstAddress, 0);
    check("st_valid", InstValid,   1);
    check("st_out",   InstOut,     9'h1A5);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("seq_addr", InstAddress, i);
    end
    check("seq_cnt",   InstCount, 5);
    check("seq_valid", InstValid, 1);
    check("seq_done",  Done,      0);
    check("seq_out",   InstOut,   9'h1A0);

    reset_start();
    repeat (3) step();
    check("pc3", InstAddress, 3);
    BranchEn = 1; BranchRel = 0; Target = 16'h0040;
    step();
    check("abs_addr", InstAddress, 16'h0040);
    check("abs_cnt",  InstCount,   4);
    BranchRel = 1; Target = 16'hFFFE;
    step();
    check("rel_addr", InstAddress, 16'h003E);
    check("rel_cnt",  InstCount,   5);
    idle_in();

    reset_start();
    repeat (7) step();
    check("pc7", InstAddress, 7);
    Stall = 1; BranchEn = 1; Target = 16'h0099;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", InstAddress, 7);
      check("stall_cnt",  InstCount,   7);
    end
    idle_in();
    step();
    check("unstall_addr", InstAddress, 8);
    check("unstall_cnt",  InstCount,   8);

    reset_start();
    repeat (8) step();
    BranchEn = 1; Target = 16'h0010;
    step();
    idle_in();
    check("h_pre_addr", InstAddress, 16'h0010);
    check("h_pre_cnt",  InstCount,   9);
    Halt = 1; Stall = 1;
    step();
    idle_in();
    check("h_done",  Done,        1);
    check("h_valid", InstValid,   0);
    check("h_out",   InstOut,     0);
    check("h_cnt",   InstCount,   10);
    check("h_addr",  InstAddress, 16'h0010);
    BranchEn = 1; Target = 16'h0077; Halt = 1;
    step();
    idle_in();
    check("dn_hold", InstAddress, 16'h0010);
    check("dn_cnt",  InstCount,   10);
    check("dn_done", Done,        1);
    Start = 1; step(); Start = 0;
    check("rs_addr",  InstAddress, 0);
    check("rs_done",  Done,        0);
    check("rs_cnt",   InstCount,   0);
    check("rs_valid", InstValid,   1);

    BranchEn = 1; Target = 16'hFFFF;
    step();
    idle_in();
    check("top_addr", InstAddress, 16'hFFFF);
    check("top_cnt",  InstCount,   1);
    step();
`ifdef FETCH_WRAP_GUARD_EN
    check("wg_done", Done,        1);
    check("wg_err",  WrapErr,     1);
    check("wg_addr", InstAddress, 16'hFFFF);
    check("wg_cnt",  InstCount,   2);
    check("wg_val",  InstValid,   0);
    Start = 1; step(); Start = 0;
    check("wg_clr", WrapErr, 0);
`else
    check("wr_addr",  InstAddress, 0);
    check("wr_valid", InstValid,   1);
    check("wr_err",   WrapErr,     0);
    check("wr_cnt",   InstCount,   2);
`endif

    reset_start();
    BranchEn = 1; Target = 16'h0025;
    step();
    idle_in();
    check("mr_pre", InstAddress, 16'h0025);
    Halt = 1; Reset = 1;
    step();
    Reset = 0; idle_in();
    check("mr_addr",  InstAddress, 0);
    check("mr_valid", InstValid,   0);
    check("mr_done",  Done,        0);
    check("mr_cnt",   InstCount,   0);

    Reset = 1; Start = 1;
    step();
    Reset = 0; Start = 0;
    check("rs_start", InstValid, 0);
    step();
    check("idle_stay", InstValid, 0);

    Start = 1; step(); Start = 0;
    BranchEn = 1; Target = 16'h0000;
    repeat (65534) @(posedge Clk);
    #1;
    check("sat_near", InstCount, 16'hFFFE);
    step();
    check("sat_max", InstCount, 16'hFFFF);
    repeat (3) step();
    check("sat_hold", InstCount, 16'hFFFF);
    idle_in();
    Halt = 1; step(); Halt = 0;
    check("sat_halt", InstCount, 16'hFFFF);
    check("sat_done", Done,      1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
